vcmac_seq: RTL and testbench

- Job sequencer for the N-lane vector complex MAC datapath; one job is a length-LEN complex dot product per lane.
- Issues operand read addresses to the operand memory and tracks outstanding reads.
- Drives the MAC control inputs: first returned operand set loads the product, every later set accumulates.
- Waits for the datapath pipeline to drain, captures overflow and pulses done to the host FSM.

---
 rtl/vcmac_seq_if.sv | 34 +++
 rtl/vcmac_seq.sv | 161 ++++++++++++++++
 tb/tb_vcmac_seq.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/vcmac_seq_if.sv
// Host, operand-memory and MAC control signals of the vector complex MAC job sequencer.
// The sequencer connects through the slave modport; the environment uses master.
interface vcmac_seq_if #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8
);
    logic              start;
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] base_addr;
    logic              abs_mode;
    logic              abort;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_rdy;
    logic              op_valid;
    logic              mac_w_en;
    logic              mac_mult;
    logic              mac_acc;
    logic              mac_abs;
    logic              mac_ovf;
    logic              busy;
    logic              done;
    logic              err_ovf;

    modport slave (
        input  start, len, base_addr, abs_mode, abort, rd_rdy, op_valid, mac_ovf,
        output rd_req, rd_addr, mac_w_en, mac_mult, mac_acc, mac_abs, busy, done, err_ovf
    );

    modport master (
        output start, len, base_addr, abs_mode, abort, rd_rdy, op_valid, mac_ovf,
        input  rd_req, rd_addr, mac_w_en, mac_mult, mac_acc, mac_abs, busy, done, err_ovf
    );
endinterface

// File: rtl/vcmac_seq.sv
// Job sequencer for the N-lane vector complex MAC: issues operand reads, steers
// load/accumulate on returned operand sets, drains the MAC pipeline and reports overflow.
module vcmac_seq #(
    parameter int ADDR_W   = 8,
    parameter int LEN_W    = 8,
    parameter int MAX_OUT  = 4,
    parameter int CMAC_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    vcmac_seq_if.slave  bus
);
    localparam int OUT_W = 4;
    localparam int DRN_W = (CMAC_LAT > 1) ? $clog2(CMAC_LAT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic                abs_q, abs_d;
    logic [LEN_W-1:0]    issued_q, issued_d;
    logic [LEN_W-1:0]    rcvd_q, rcvd_d;
    logic [OUT_W-1:0]    outst_q, outst_d;
    logic                first_q, first_d;
    logic                err_q, err_d;
    logic                armed_q, armed_d;
    logic [CMAC_LAT-1:0] fw_pipe_q, fw_pipe_d;
    logic [DRN_W-1:0]    drn_q, drn_d;

    logic accept;
    logic ret;
    logic ovf_win;

    // Overflow is only meaningful once the first loaded product has reached the MAC output.
    assign ovf_win = armed_q | fw_pipe_q[CMAC_LAT-1];

    // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        base_d    = base_q;
        abs_d     = abs_q;
        issued_d  = issued_q;
        rcvd_d    = rcvd_q;
        outst_d   = outst_q;
        first_d   = first_q;
        err_d     = err_q;
        drn_d     = drn_q;
        armed_d   = ovf_win;
        fw_pipe_d = CMAC_LAT'({fw_pipe_q, 1'b0});
        accept    = 1'b0;
        ret       = 1'b0;

        bus.rd_req   = 1'b0;
        bus.rd_addr  = base_q + ADDR_W'(issued_q);
        bus.mac_w_en = 1'b0;
        bus.mac_mult = 1'b0;
        bus.mac_acc  = 1'b0;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    len_d     = bus.len;
                    base_d    = bus.base_addr;
                    abs_d     = bus.abs_mode;
                    err_d     = 1'b0;
                    first_d   = 1'b1;
                    issued_d  = '0;
                    rcvd_d    = '0;
                    outst_d   = '0;
                    drn_d     = '0;
                    armed_d   = 1'b0;
                    fw_pipe_d = '0;
                    state_d   = (bus.len == '0) ? S_DONE : S_RUN;
                end
            end

            S_RUN: begin
                bus.busy = 1'b1;
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else begin
                    bus.rd_req = (issued_q < len_q) && (outst_q < OUT_W'(MAX_OUT));
                    accept     = bus.rd_req & bus.rd_rdy;
                    ret        = bus.op_valid & (outst_q != '0);

                    bus.mac_w_en = ret;
                    bus.mac_mult = ret & first_q;
                    bus.mac_acc  = ret & ~first_q;
                    fw_pipe_d[0] = ret & first_q;
                    if (ret) first_d = 1'b0;

                    issued_d = issued_q + LEN_W'(accept);
                    rcvd_d   = rcvd_q + LEN_W'(ret);
                    outst_d  = outst_q + OUT_W'(accept) - OUT_W'(ret);
                    err_d    = err_q | (bus.mac_ovf & ovf_win);

                    if (ret && (rcvd_q + 1'b1 == len_q)) begin
                        state_d = S_DRAIN;
                        drn_d   = '0;
                    end
                end
            end

            S_DRAIN: begin
                bus.busy = 1'b1;
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else begin
                    err_d = err_q | (bus.mac_ovf & ovf_win);
                    if (drn_q == DRN_W'(CMAC_LAT - 1)) state_d = S_DONE;
                    else                               drn_d   = drn_q + 1'b1;
                end
            end

            S_DONE: begin
                bus.done = 1'b1;
                state_d  = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase

        bus.mac_abs = bus.busy & abs_q;
        bus.err_ovf = err_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            base_q    <= '0;
            abs_q     <= 1'b0;
            issued_q  <= '0;
            rcvd_q    <= '0;
            outst_q   <= '0;
            first_q   <= 1'b0;
            err_q     <= 1'b0;
            armed_q   <= 1'b0;
            fw_pipe_q <= '0;
            drn_q     <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            base_q    <= base_d;
            abs_q     <= abs_d;
            issued_q  <= issued_d;
            rcvd_q    <= rcvd_d;
            outst_q   <= outst_d;
            first_q   <= first_d;
            err_q     <= err_d;
            armed_q   <= armed_d;
            fw_pipe_q <= fw_pipe_d;
            drn_q     <= drn_d;
        end
    end
endmodule

// File: tb/tb_vcmac_seq.sv
// Directed cycle-by-cycle bench for vcmac_seq; output vector per step is
// {rd_req, w_en, mult, acc, abs, busy, done, err_ovf}, rd_addr checked when rd_req is expected.
module tb_vcmac_seq;
    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   step     = 0;

    vcmac_seq_if #(.ADDR_W(8), .LEN_W(8)) bus ();

    vcmac_seq #(.ADDR_W(8), .LEN_W(8), .MAX_OUT(4), .CMAC_LAT(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] out_vec;
    assign out_vec = {bus.rd_req, bus.mac_w_en, bus.mac_mult, bus.mac_acc,
                      bus.mac_abs, bus.busy, bus.done, bus.err_ovf};

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    // Drive one cycle of inputs just after the edge, check outputs at the falling edge.
    task automatic cyc(input logic st, input logic ov, input logic rdy, input logic ab,
                       input logic ovf, input logic [7:0] e_out, input logic [7:0] e_addr);
        bus.start    = st;
        bus.op_valid = ov;
        bus.rd_rdy   = rdy;
        bus.abort    = ab;
        bus.mac_ovf  = ovf;
        @(negedge clk);
        check($sformatf("step%0d_out", step), out_vec, e_out);
        if (e_out[7]) check($sformatf("step%0d_addr", step), bus.rd_addr, e_addr);
        step++;
        @(posedge clk);
        #1;
    endtask

    task automatic job(input logic [7:0] l, input logic [7:0] b, input logic a);
        bus.len       = l;
        bus.base_addr = b;
        bus.abs_mode  = a;
    endtask

    initial begin
        rst = 1'b0;
        bus.start = 1'b0; bus.len = '0; bus.base_addr = '0; bus.abs_mode = 1'b0;
        bus.abort = 1'b0; bus.rd_rdy = 1'b0; bus.op_valid = 1'b0; bus.mac_ovf = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out", out_vec, 8'b0000_0000);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // len=4 base 0x10, each op_valid two cycles after its accept
        job(8'd4, 8'h10, 1'b0);
        cyc(1, 0, 1, 0, 0, 8'b0000_0000, 8'h00);
        cyc(0, 0, 1, 0, 0, 8'b1000_0100, 8'h10);
        cyc(0, 0, 1, 0, 0, 8'b1000_0100, 8'h11);
        cyc(0, 1, 1, 0, 0, 8'b1110_0100, 8'h12);
        cyc(0, 1, 1, 0, 0, 8'b1101_0100, 8'h13);
        cyc(0, 1, 1, 0, 0, 8'b0101_0100, 8'h00);
        cyc(0, 1, 1, 0, 0, 8'b0101_0100, 8'h00);
        cyc(0, 0, 1, 0, 0, 8'b0000_0100, 8'h00);
        cyc(0, 0, 1, 0, 0, 8'b0000_0010, 8'h00);

        // back-to-back start: len=8 base 0x20 abs, returns held off until MAX_OUT reached
        job(8'd8, 8'h20, 1'b1);
        cyc(1, 0, 1, 0, 0, 8'b0000_0000, 8'h00);
        cyc(0, 0, 1, 0, 0, 8'b1000_1100, 8'h20);
        cyc(0, 0, 1, 0, 0, 8'b1000_1100, 8'h21);
        cyc(0, 0, 1, 0, 0, 8'b1000_1100, 8'h22);
        cyc(0, 0, 1, 0, 0, 8'b1000_1100, 8'h23);
        cyc(0, 0, 1, 0, 0, 8'b0000_1100, 8'h00);
        cyc(0, 0, 1, 0, 0, 8'b0000_1100, 8'h00);
        cyc(0, 1, 1, 0, 0, 8'b0110_1100, 8'h00);
        cyc(0, 1, 1, 0, 0, 8'b1101_1100, 8'h24);
        cyc(0, 1, 1, 0, 0, 8'b1101_1100, 8'h25);
        cyc(0, 1, 1, 0, 0, 8'b1101_1100, 8'h26);
        cyc(0, 1, 1, 0, 0, 8'b1101_1100, 8'h27);
        cyc(0, 1, 1, 0, 0, 8'b0101_1100, 8'h00);
        cyc(0, 1, 1, 0, 0, 8'b0101_1100, 8'h00);
        cyc(0, 1, 1, 0, 0, 8'b0101_1100, 8'h00);
        cyc(0, 0, 1, 0, 0, 8'b0000_1100, 8'h00);
        cyc(0, 0, 1, 0, 0, 8'b0000_0010, 8'h00);
        cyc(0, 0, 1, 0, 0, 8'b0000_0000, 8'h00);

        // len=0: straight to done; start/abort/op_valid in DONE have no effect
        job(8'd0, 8'h30, 1'b0);
        cyc(1, 0, 1, 0, 0, 8'b0000_0000, 8'h00);
        cyc(1, 1, 1, 1, 0, 8'b0000_0010, 8'h00);
        cyc(0, 1, 1, 0, 0, 8'b0000_0000, 8'h00);

        // base 0xFE len=3 wraps; overflow during DRAIN becomes sticky
        job(8'd3, 8'hFE, 1'b0);
        cyc(1, 0, 1, 0, 0, 8'b0000_0000, 8'h00);
        cyc(0, 0, 1, 0, 0, 8'b1000_0100, 8'hFE);
        cyc(0, 1, 1, 0, 0, 8'b1110_0100, 8'hFF);
        cyc(0, 1, 1, 0, 0, 8'b1101_0100, 8'h00);
        cyc(0, 1, 1, 0, 0, 8'b0101_0100, 8'h00);
        cyc(0, 0, 1, 0, 1, 8'b0000_0100, 8'h00);
        cyc(0, 0, 1, 0, 0, 8'b0000_0011, 8'h00);
        cyc(0, 0, 1, 0, 0, 8'b0000_0001, 8'h00);

        // len=5: next start clears err; ovf before window ignored; abort after 2 returns
        job(8'd5, 8'h40, 1'b0);
        cyc(1, 0, 1, 0, 0, 8'b0000_0001, 8'h00);
        cyc(0, 0, 1, 0, 0, 8'b1000_0100, 8'h40);
        cyc(0, 1, 1, 0, 1, 8'b1110_0100, 8'h41);
        cyc(0, 1, 1, 0, 0, 8'b1101_0100, 8'h42);
        cyc(0, 0, 1, 1, 1, 8'b0000_0100, 8'h00);
        cyc(0, 1, 1, 0, 0, 8'b0000_0000, 8'h00);
        cyc(0, 0, 1, 0, 0, 8'b0000_0000, 8'h00);

        // fresh len=1 job uses mult only and completes
        job(8'd1, 8'h50, 1'b0);
        cyc(1, 0, 1, 0, 0, 8'b0000_0000, 8'h00);
        cyc(0, 0, 1, 0, 0, 8'b1000_0100, 8'h50);
        cyc(0, 1, 1, 0, 0, 8'b0110_0100, 8'h00);
        cyc(0, 0, 1, 0, 0, 8'b0000_0100, 8'h00);
        cyc(0, 0, 1, 0, 0, 8'b0000_0010, 8'h00);

        // reset asserted mid-job returns to idle immediately
        job(8'd2, 8'h60, 1'b1);
        cyc(1, 0, 1, 0, 0, 8'b0000_0000, 8'h00);
        cyc(0, 0, 1, 0, 0, 8'b1000_1100, 8'h60);
        rst = 1'b0;
        #2;
        check("rst_mid_job", out_vec, 8'b0000_0000);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc(0, 1, 1, 0, 0, 8'b0000_0000, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
